// File: rtl/color_demixer_pkg.sv
// color_demixer_pkg
//   Shared types and constants for the RGB PWM demixer. It holds the FSM state
//   encoding, the frame geometry, the channel width and the channel order
//   inside the packed {R,G,B} buses.
package color_demixer_pkg;

  typedef enum logic {
    ACQUIRE = 1'b0,
    MEASURE = 1'b1
  } state_e;

  localparam int FRAME_LEN = 256;
  localparam int CH_W      = 8;
  // One extra bit so that a line stuck high for a whole frame (256 cycles)
  // can be told apart from the largest legal code (255).
  localparam int HC_W      = CH_W + 1;

  // Channel index in rgb_pwm_i and in the 3-entry per-channel arrays.
  localparam int R = 2;
  localparam int G = 1;
  localparam int B = 0;

  typedef logic [CH_W-1:0] pos_t;
  typedef logic [HC_W-1:0] hc_t;

  localparam pos_t POS_LAST = pos_t'(FRAME_LEN - 1);
  localparam hc_t  HC_MAX   = hc_t'(FRAME_LEN);

endpackage

// File: rtl/pwm_channel_meter.sv
// pwm_channel_meter
//   Measures one synchronised PWM line over one frame.
//   Ports:
//     clk_i, rst_ni : clock, synchronous active-low reset
//     pwm_s         : synchronised PWM line
//     pos           : frame position of the current cycle (0 = first cycle)
//     frame_s       : synchronised end-of-frame strobe; clears the state
//     clear         : extra clear (frame discarded, or FSM not measuring)
//     hc            : high count including the current cycle, saturating at 256
//     fmt_err       : format flag including the current cycle
//   Both outputs already include the current sample, so the top level can
//   judge a frame in its strobe cycle, whose sample is part of that frame.
module pwm_channel_meter
  import color_demixer_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic pwm_s,
  input  pos_t pos,
  input  logic frame_s,
  input  logic clear,
  output hc_t  hc,
  output logic fmt_err
);

  hc_t  hc_q;
  logic prev_q;
  logic fmt_q;
  logic rise;

  assign rise = pwm_s & ~prev_q;

  // Saturating add of the current sample.
  assign hc = (pwm_s && (hc_q != HC_MAX)) ? hc_q + hc_t'(1) : hc_q;

  // A legal pulse may only rise in the first cycle of the frame; prev_q then
  // holds the previous frame's strobe-cycle sample.
  assign fmt_err = fmt_q | (rise & (pos != '0));

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples the pre-edge values no matter the statement order.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      hc_q   <= '0;
      prev_q <= 1'b0;
      fmt_q  <= 1'b0;
    end else begin
      // The edge detector keeps tracking across frame boundaries.
      prev_q <= pwm_s;
      if (clear || frame_s) begin
        hc_q  <= '0;
        fmt_q <= 1'b0;
      end else begin
        hc_q  <= hc;
        fmt_q <= fmt_err;
      end
    end
  end

endmodule

// File: rtl/color_demixer.sv
// color_demixer
//   Recovers a 24-bit RGB code from three PWM lines and the mixer's
//   end-of-frame strobe by measuring each line's high time over a 256-cycle
//   frame, and presents each code on a valid/ready output.
//   Parameters:
//     SYNC_STAGES : synchroniser depth on rgb_pwm_i and frame_i (1..4)
//   Ports:
//     clk_i, rst_ni : clock, synchronous active-low reset
//     rgb_pwm_i     : PWM lines {R,G,B}, asynchronous to clk_i
//     frame_i       : one-cycle strobe in the last cycle of each frame
//     color_o       : decoded code {R,G,B}
//     valid_o       : color_o holds an unconsumed code
//     ready_i       : consumer accepts when valid_o && ready_i
//     locked_o      : FSM is in MEASURE
//     err_o         : one-cycle pulse, the current frame was discarded
//     overrun_o     : one-cycle pulse, an unconsumed code was overwritten
module color_demixer
  import color_demixer_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [2:0]          rgb_pwm_i,
  input  logic                frame_i,
  output logic [3*CH_W-1:0]   color_o,
  output logic                valid_o,
  input  logic                ready_i,
  output logic                locked_o,
  output logic                err_o,
  output logic                overrun_o
);

  // Strobe and PWM lines share one shift register so that their relative
  // alignment survives synchronisation.
  logic [3:0] sync_q [SYNC_STAGES];
  logic [2:0] pwm_s;
  logic       frame_s;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= {frame_i, rgb_pwm_i};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign pwm_s   = sync_q[SYNC_STAGES-1][2:0];
  assign frame_s = sync_q[SYNC_STAGES-1][3];

  state_e            state_q, state_d;
  pos_t              pos_q, pos_d;
  logic              meter_clear;
  hc_t               hc [3];
  logic [2:0]        fmt_err;

  for (genvar ch = 0; ch < 3; ch++) begin : g_meter
    pwm_channel_meter u_meter (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .pwm_s   (pwm_s[ch]),
      .pos     (pos_q),
      .frame_s (frame_s),
      .clear   (meter_clear),
      .hc      (hc[ch]),
      .fmt_err (fmt_err[ch])
    );
  end

  logic              any_sat;
  logic              frame_bad;
  logic [3*CH_W-1:0] color_d;
  logic              publish;
  logic              err_d;

  assign any_sat   = (hc[R] == HC_MAX) | (hc[G] == HC_MAX) | (hc[B] == HC_MAX);
  assign frame_bad = (pos_q != POS_LAST) | (|fmt_err) | any_sat;
  assign color_d   = {hc[R][CH_W-1:0], hc[G][CH_W-1:0], hc[B][CH_W-1:0]};

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    pos_d       = pos_q;
    meter_clear = 1'b0;
    publish     = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      ACQUIRE: begin
        meter_clear = 1'b1;
        pos_d       = '0;
        if (frame_s) state_d = MEASURE;
      end
      MEASURE: begin
        if (frame_s) begin
          pos_d = '0;
          if (frame_bad) err_d   = 1'b1;
          else           publish = 1'b1;
        end else if (pos_q == POS_LAST) begin
          // Strobe missing where the frame should end: sync is lost.
          state_d     = ACQUIRE;
          pos_d       = '0;
          meter_clear = 1'b1;
          err_d       = 1'b1;
        end else begin
          pos_d = pos_q + pos_t'(1);
        end
      end
      default: begin
        state_d     = ACQUIRE;
        pos_d       = '0;
        meter_clear = 1'b1;
      end
    endcase
  end

  logic [3*CH_W-1:0] color_q;
  logic              valid_q;
  logic              err_q;
  logic              overrun_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= ACQUIRE;
      pos_q     <= '0;
      color_q   <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pos_q     <= pos_d;
      err_q     <= err_d;
      overrun_q <= publish & valid_q & ~ready_i;
      // A publish overrides a same-cycle accept: the new code stays valid.
      if (publish) begin
        color_q <= color_d;
        valid_q <= 1'b1;
      end else if (valid_q && ready_i) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign color_o   = color_q;
  assign valid_o   = valid_q;
  assign err_o     = err_q;
  assign overrun_o = overrun_q;
  assign locked_o  = (state_q == MEASURE);

endmodule
